// File: rtl/counter_heap_sched_pkg.sv
// Shared types for the counter heap scheduler.
// Holds the FSM encoding, decay defaults and the update entry width.
package counter_heap_sched_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      DECAY_WAIT = 2'd1,
      DECAY      = 2'd2
   } state_t;

   localparam int DEF_DECAYPERIOD = 1024;

   // One queued update is {addr, taken}.
   function automatic int entry_w(input int pw);
      return pw + 1;
   endfunction

endpackage

// File: rtl/counter_heap_sched_if.sv
// Fetch/commit request side and counter table side of the scheduler.
// master drives requests; slave is the scheduler itself.
interface counter_heap_sched_if #(
   parameter int COUNTERPW = 6,
   parameter int UPQPW     = 2
);
   logic                 ReadReq;
   logic [COUNTERPW-1:0] ReadReqAddr;
   logic                 ReadDataValid;
   logic                 UpReq;
   logic [COUNTERPW-1:0] UpReqAddr;
   logic                 UpReqTaken;
   logic                 UpReady;
   logic                 FlushReq;
   logic [COUNTERPW-1:0] TabUpAddr;
   logic                 TabUpdateAble;
   logic                 TabRightOrFault;
   logic [COUNTERPW-1:0] TabReadAddr;
   logic                 TabReadAble;
   logic                 TabAttenuation;
   logic [UPQPW:0]       QueueCount;

   modport master (
      output ReadReq, ReadReqAddr, UpReq, UpReqAddr,
      output UpReqTaken, FlushReq,
      input  ReadDataValid, UpReady, TabUpAddr, TabUpdateAble,
      input  TabRightOrFault, TabReadAddr, TabReadAble,
      input  TabAttenuation, QueueCount
   );

   modport slave (
      input  ReadReq, ReadReqAddr, UpReq, UpReqAddr,
      input  UpReqTaken, FlushReq,
      output ReadDataValid, UpReady, TabUpAddr, TabUpdateAble,
      output TabRightOrFault, TabReadAddr, TabReadAble,
      output TabAttenuation, QueueCount
   );
endinterface

// File: rtl/counter_heap_sched_sync_fifo_cnt.sv
// Synchronous FIFO with occupancy count and flush.
// Flush wins over push and pop in the same cycle.
module sync_fifo_cnt #(
   parameter int W     = 7,
   parameter int DEPTH = 4,
   parameter int PW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   count
);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic          wr;
   logic          rd;

   assign full  = count == (PW+1)'(DEPTH);
   assign empty = count == '0;
   assign wr    = push && !full && !flush;
   assign rd    = pop && !empty && !flush;
   assign dout  = mem[rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         count <= count + (PW+1)'(wr) - (PW+1)'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= din;
   end
endmodule

// File: rtl/counter_heap_sched.sv
// Read/update scheduler for a 2-bit counter table with periodic decay.
// Decay timer and DECAY_WAIT/DECAY states exist only with COUNTER_HEAP_DECAY_EN.
module counter_heap_sched
   import counter_heap_sched_pkg::*;
#(
   parameter int COUNTERPW   = 6,
   parameter int UPQDEPTH    = 4,
   parameter int UPQPW       = 2,
   parameter int DECAYPERIOD = DEF_DECAYPERIOD,
   parameter int DECAYPW     = 10
) (
   input logic                Clk,
   input logic                Rest,
   counter_heap_sched_if.slave bus
);
   localparam int EW = entry_w(COUNTERPW);

   logic [EW-1:0] head;
   logic          full;
   logic          empty;
   logic          pop;
   logic          run;

   if (UPQDEPTH != (2 ** UPQPW) || UPQDEPTH < 2 ||
       DECAYPERIOD < 4 || (2 ** DECAYPW) < DECAYPERIOD) begin : g_bad_cfg
      $error("counter_heap_sched: bad parameter set");
   end

   assign bus.TabReadAble = bus.ReadReq;
   assign bus.TabReadAddr = bus.ReadReqAddr;
   assign bus.UpReady     = !full;
   assign pop             = run && !empty && !bus.FlushReq;

   sync_fifo_cnt #(
      .W    (EW),
      .DEPTH(UPQDEPTH),
      .PW   (UPQPW)
   ) u_fifo (
      .clk  (Clk),
      .rst_n(Rest),
      .flush(bus.FlushReq),
      .push (bus.UpReq),
      .pop  (pop),
      .din  ({bus.UpReqAddr, bus.UpReqTaken}),
      .dout (head),
      .full (full),
      .empty(empty),
      .count(bus.QueueCount)
   );

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         bus.ReadDataValid   <= 1'b0;
         bus.TabUpdateAble   <= 1'b0;
         bus.TabUpAddr       <= '0;
         bus.TabRightOrFault <= 1'b0;
      end else begin
         bus.ReadDataValid <= bus.ReadReq;
         bus.TabUpdateAble <= pop;
         if (pop) {bus.TabUpAddr, bus.TabRightOrFault} <= head;
      end
   end

`ifdef COUNTER_HEAP_DECAY_EN
   state_t             state;
   state_t             state_nx;
   logic [DECAYPW-1:0] timer;
   logic [DECAYPW-1:0] timer_nx;

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         state <= RUN;
         timer <= '0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
      end
   end

   // Attenuation waits for the last issued update to retire.
   always_comb begin
      state_nx = state;
      timer_nx = timer;
      unique case (state)
         RUN: begin
            if (timer == DECAYPW'(DECAYPERIOD - 1)) begin
               timer_nx = '0;
               state_nx = DECAY_WAIT;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         DECAY_WAIT: if (!bus.TabUpdateAble) state_nx = DECAY;
         DECAY:      state_nx = RUN;
         default:    state_nx = RUN;
      endcase
   end

   assign run                = state == RUN;
   assign bus.TabAttenuation = state == DECAY;
`else
   assign run                = 1'b1;
   assign bus.TabAttenuation = 1'b0;
`endif
endmodule

// File: doc/counter_heap_sched.md
Name: counter_heap_sched

Overview:
- Scheduler in front of one 2-bit saturating-counter table (branch-direction predictor heap).
- Grants the fetch-side read port every cycle and buffers commit-side updates in a small FIFO, draining one update per cycle.
- Periodically issues a table-wide attenuation pulse, but only in a cycle with no update, so the two never collide.
- Sits between predictor fetch/commit logic and the counter table.

Parameters:
- COUNTERPW, 6, table address width.
- UPQDEPTH, 4, update FIFO entries (power of 2, ≥2).
- UPQPW, 2, log2(UPQDEPTH).
- DECAYPERIOD, 1024, cycles between attenuation requests (≥4).
- DECAYPW, 10, decay timer width; must satisfy 2^DECAYPW ≥ DECAYPERIOD.

Ports:
- Clk  in  1  clock.
- Rest  in  1  asynchronous active-low reset.
- ReadReq  in  1  fetch read request.
- ReadReqAddr  in  COUNTERPW  fetch index.
- ReadDataValid  out  1  table output valid this cycle; 1 cycle after ReadReq.
- UpReq  in  1  commit update request.
- UpReqAddr  in  COUNTERPW  update index.
- UpReqTaken  in  1  branch outcome: 1 = taken (increment), 0 = not taken (decrement).
- UpReady  out  1  FIFO not full.
- FlushReq  in  1  drop all queued updates.
- TabUpAddr  out  COUNTERPW  to table update address.
- TabUpdateAble  out  1  to table update enable.
- TabRightOrFault  out  1  to table increment/decrement select.
- TabReadAddr  out  COUNTERPW  to table read address.
- TabReadAble  out  1  to table read enable.
- TabAttenuation  out  1  to table decay pulse.
- QueueCount  out  UPQPW+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - All registered outputs are 0; QueueCount = 0; UpReady = 1.
  - Decay timer = 0; state = RUN.
- Read path: combinational pass-through.
  - TabReadAble = ReadReq; TabReadAddr = ReadReqAddr.
  - ReadDataValid is ReadReq registered one cycle, matching the table's 1-cycle read latency.
  - Reads are never stalled.
- Update FIFO: an entry {addr, taken} is written when UpReq && UpReady.
  - UpReq while full is ignored; the caller must hold the request.
  - Simultaneous push and pop while full is not allowed: UpReady is based on the current count only.
  - Simultaneous push and pop otherwise leaves the count unchanged.
- Update issue (registered):
  - In RUN, when the FIFO is non-empty, pop the head and drive TabUpdateAble = 1, TabUpAddr = head addr, TabRightOrFault = head taken on the next cycle.
  - Throughput is 1 update per cycle.
  - Read and update to the same address in one cycle is allowed; the read returns the pre-update value.
- State machine RUN / DECAY_WAIT / DECAY:
  - RUN: the timer increments each cycle. At timer == DECAYPERIOD-1, the timer clears and the state goes to DECAY_WAIT.
  - DECAY_WAIT: no pops are issued. Pushes continue. Go to DECAY the first cycle after the last issued update has retired, i.e. TabUpdateAble is 0 this cycle.
  - DECAY: TabAttenuation = 1 for exactly one cycle with TabUpdateAble = 0, then return to RUN.
  - The timer holds in DECAY_WAIT and DECAY.
- Flush:
  - FlushReq empties the FIFO on the next edge. QueueCount = 0 and no pop is issued that cycle.
  - An update already driven to the table this cycle completes.
  - A push arriving in the same cycle as FlushReq is dropped.
  - Flush does not change the state or the timer.
- Pointer wrap: read and write pointers are UPQPW bits and wrap modulo UPQDEPTH. Occupancy is tracked in the separate QueueCount register.

Optional Feature:
- Macro COUNTER_HEAP_DECAY_EN.
- Defined: decay timer and the DECAY_WAIT/DECAY states exist, as above.
- Undefined: no timer, FSM fixed at RUN, TabAttenuation tied to 0, updates drain continuously.

Decomposition:
- Shared package / include: state encodings (RUN = 2'd0, DECAY_WAIT = 2'd1, DECAY = 2'd2), the update entry width (COUNTERPW+1), and the default DECAYPERIOD.
- One natural sub-module: sync_fifo_cnt — a parameterised synchronous FIFO with count, flush, push/pop and full/empty.
- The FSM and the read path stay in the top level.

Test Plan:
- Reset, then ReadReq = 1 with ReadReqAddr = 6'h15 -> same cycle TabReadAble = 1, TabReadAddr = 6'h15; next cycle ReadDataValid = 1.
- 5 back-to-back UpReq (addr 1..5, UPQDEPTH = 4), no pop possible (held in DECAY_WAIT) -> UpReady = 0 after 4 pushes; 5th is held off; QueueCount = 4.
- Pushes addr 7 taken, addr 7 not-taken in RUN -> TabUpdateAble high for 2 consecutive cycles; TabRightOrFault 1 then 0; order preserved.
- DECAYPERIOD = 8 with a continuous update stream -> at cycle 8 pops stop; after the in-flight update, exactly one TabAttenuation pulse with TabUpdateAble = 0; then draining resumes.
- QueueCount = 3, FlushReq plus UpReq in the same cycle -> next cycle QueueCount = 0, no TabUpdateAble, the pushed entry is lost.
- Rest asserted mid-DECAY_WAIT -> TabAttenuation / TabUpdateAble drop to 0 immediately (asynchronously); after release the timer restarts from 0 and the FIFO is empty.
